// File: rtl/tx_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_byte_fifo
//  Description : Byte FIFO between bridge_tx and uart_tx on the host response
//                path. First-word-fall-through with a registered output
//                stage, fill level, almost-full flag, high-water mark and a
//                saturating stall counter for bus debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_byte_fifo #(
   parameter int DEPTH     = 64,
   parameter int AFULL_LVL = 56
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 data_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic [7:0]                 data_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       almost_full_o,
   output logic [$clog2(DEPTH):0]     hwm_o,
   output logic [15:0]                stall_cnt_o,
   input  logic                       clear_stats_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] C_AFULL   = PW'(AFULL_LVL);
   localparam logic [15:0]   C_STL_MAX = 16'hFFFF;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] hwm_q, hwm_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic [15:0]   stall_q, stall_d;
   logic [7:0]    mem_q [DEPTH];

   logic          full_w;
   logic          push_w;
   logic          pop_w;
   logic [PW-1:0] count_w;
   logic [PW-1:0] count_next_w;

   // Status derived purely from registered pointers: no input-to-output paths.
   assign full_w        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_w       = wr_ptr_q - rd_ptr_q;
   assign ready_o       = !full_w;
   assign almost_full_o = (count_w >= C_AFULL);
   assign count_o       = count_w;
   assign hwm_o         = hwm_q;
   assign stall_cnt_o   = stall_q;
   assign data_o        = data_q;
   assign valid_o       = valid_q;

   // The output register always holds the oldest stored byte, so valid_q
   // tracks "count != 0" and a pop is simply valid & ready.
   assign push_w = valid_i && !full_w;
   assign pop_w  = valid_q && ready_i;

   // Next-state: pointers, output stage preload and debug statistics.
   always_comb begin
      wr_ptr_d     = wr_ptr_q + PW'(push_w);
      rd_ptr_d     = rd_ptr_q + PW'(pop_w);
      count_next_w = wr_ptr_d - rd_ptr_d;
      valid_d      = (count_next_w != '0);
      data_d       = data_q;
      if (valid_d) begin
         // The head entry may be the one being written on this very edge;
         // bypass it from data_i since the array has not been updated yet.
         if (rd_ptr_d == wr_ptr_q) begin
            data_d = data_i;
         end else begin
            data_d = mem_q[rd_ptr_d[AW-1:0]];
         end
      end

      hwm_d   = hwm_q;
      stall_d = stall_q;
      if (clear_stats_i) begin
         hwm_d   = count_w;
         stall_d = '0;
      end else begin
         if (count_next_w > hwm_q) begin
            hwm_d = count_next_w;
         end
         if (valid_i && full_w && (stall_q != C_STL_MAX)) begin
            stall_d = stall_q + 16'd1;
         end
      end
   end

   // Control and output-stage registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         hwm_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         stall_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         hwm_q    <= hwm_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         stall_q  <= stall_d;
      end
   end

   // Storage array; contents are don't-care after reset since pointers clear.
   always_ff @(posedge clk) begin
      if (push_w) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tx_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_byte_fifo
//  Description : Self-checking bench for tx_byte_fifo against a queue-based
//                reference model; directed scenarios plus random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_byte_fifo;

   localparam int DEPTH = 64;
   localparam int AFULL = 56;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  data_i = '0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic [6:0]  count_o;
   logic        almost_full_o;
   logic [6:0]  hwm_o;
   logic [15:0] stall_cnt_o;
   logic        clear_stats_i = 1'b0;

   tx_byte_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
      .clk           (clk),
      .rst           (rst),
      .data_i        (data_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .data_o        (data_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .count_o       (count_o),
      .almost_full_o (almost_full_o),
      .hwm_o         (hwm_o),
      .stall_cnt_o   (stall_cnt_o),
      .clear_stats_i (clear_stats_i)
   );

   always #5 clk = ~clk;

   // Reference model state
   byte unsigned m_q[$];
   int           m_hwm;
   int           m_stall;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_hwm   = 0;
      m_stall = 0;
   endtask

   // Apply one clock edge to the model using the inputs currently driven.
   task automatic model_edge();
      int  sz;
      bit  full, push, pop;
      sz   = m_q.size();
      full = (sz == DEPTH);
      push = valid_i && !full;
      pop  = (sz != 0) && ready_i;
      if (clear_stats_i) begin
         m_hwm   = sz;
         m_stall = 0;
      end else if (valid_i && full && m_stall < 65535) begin
         m_stall++;
      end
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(data_i);
      if (!clear_stats_i && m_q.size() > m_hwm) m_hwm = m_q.size();
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = m_q.size();
      check({tag, ".count"}, int'(count_o), sz);
      check({tag, ".ready"}, int'(ready_o), int'(sz != DEPTH));
      check({tag, ".valid"}, int'(valid_o), int'(sz != 0));
      check({tag, ".afull"}, int'(almost_full_o), int'(sz >= AFULL));
      check({tag, ".hwm"},   int'(hwm_o), m_hwm);
      check({tag, ".stall"}, int'(stall_cnt_o), m_stall);
      if (sz != 0) check({tag, ".data"}, int'(data_o), int'(m_q[0]));
   endtask

   task automatic step(input string tag, input logic v, input logic [7:0] d,
                       input logic r, input logic c);
      valid_i       = v;
      data_i        = d;
      ready_i       = r;
      clear_stats_i = c;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse, asserted away from the clock edge.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #2;
      model_reset();
      check_all(tag);
      check({tag, ".data0"}, int'(data_o), 0);
      @(negedge clk);
      valid_i = 1'b0; ready_i = 1'b0; clear_stats_i = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_all({tag, ".post"});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      byte unsigned msg [7];
      int vp, rp;
      msg = '{8'h4D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
      model_reset();
      #3;
      do_reset("rst0");

      // 1: short message, free-flowing sink; first byte valid one cycle later
      for (int i = 0; i < 7; i++) begin
         step("t1", 1'b1, msg[i], 1'b1, 1'b0);
         if (i == 0) check("t1.first_valid", int'(valid_o), 1);
      end
      for (int i = 0; i < 4; i++) step("t1d", 1'b0, 8'h00, 1'b1, 1'b0);

      // 2: fill to full with sink stalled
      for (int i = 0; i < 64; i++) step("t2", 1'b1, 8'(i), 1'b0, 1'b0);
      check("t2.full_count", int'(count_o), 64);
      check("t2.ready_low", int'(ready_o), 0);

      // 3: hold full with valid_i high, then drain
      for (int i = 0; i < 10; i++) step("t3s", 1'b1, 8'hEE, 1'b0, 1'b0);
      check("t3.stall10", int'(stall_cnt_o), 10);
      for (int i = 0; i < 66; i++) step("t3d", 1'b0, 8'h00, 1'b1, 1'b0);

      // 4: 200-byte stream with push and pop every cycle
      for (int i = 0; i < 200; i++) step("t4", 1'b1, 8'($urandom), 1'b1, 1'b0);
      check("t4.count1", int'(count_o), 1);
      step("t4d", 1'b0, 8'h00, 1'b1, 1'b0);

      // 5: reset mid-burst, then a single byte
      for (int i = 0; i < 20; i++) step("t5", 1'b1, 8'($urandom), 1'b0, 1'b0);
      do_reset("t5rst");
      step("t5a", 1'b1, 8'hA5, 1'b0, 1'b0);
      check("t5.a5", int'(data_o), 8'hA5);
      step("t5b", 1'b0, 8'h00, 1'b1, 1'b0);

      // 6: build hwm=40, drain to 5, clear stats
      for (int i = 0; i < 40; i++) step("t6f", 1'b1, 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 35; i++) step("t6d", 1'b0, 8'h00, 1'b1, 1'b0);
      step("t6c", 1'b0, 8'h00, 1'b0, 1'b1);
      check("t6.hwm5", int'(hwm_o), 5);
      for (int i = 0; i < 6; i++) step("t6e", 1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic in phases with varying producer/consumer pressure
      for (int ph = 0; ph < 12; ph++) begin
         vp = $urandom_range(10, 100);
         rp = $urandom_range(5, 100);
         for (int i = 0; i < 300; i++) begin
            step("rnd",
                 logic'($urandom_range(99, 0) < vp),
                 8'($urandom),
                 logic'($urandom_range(99, 0) < rp),
                 logic'($urandom_range(199, 0) == 0));
         end
         if (ph == 6) do_reset("rnd_rst");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
